// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - instruction fetch stage with 2-entry prefetch FIFO and IF/ID register
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = 32'h0000_0020
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid
);

  // Fetch state
  logic [31:0] fpc_q, fpc_d;
  logic        out_q, out_d;
  logic        sq_q, sq_d;
  logic [31:0] rec_q, rec_d;

  // Prefetch FIFO: entry 0 is always the head, entry 1 the tail
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] ent0_ir_q, ent0_ir_d;
  logic [31:0] ent0_pc_q, ent0_pc_d;
  logic [31:0] ent1_ir_q, ent1_ir_d;
  logic [31:0] ent1_pc_q, ent1_pc_d;

  // IF/ID register
  logic [31:0] ifid_ir_q, ifid_ir_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        accept;
  logic        resp;
  logic        pop;
  logic [1:0]  cnt_mid;
  logic        unused_pc_bits;

  // The low bits of the redirect target are ignored; the target is forced word aligned
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Issue only with nothing outstanding and room guaranteed for the response
  assign imem_req   = ~out_q & ~redirect & ~reset & (cnt_q != 2'd2);
  assign imem_addr  = fpc_q;
  assign ifid_ir    = ifid_ir_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;

  // Next-state: redirect flushes everything, otherwise pop to IF/ID, push responses, issue requests
  always_comb begin
    fpc_d        = fpc_q;
    out_d        = out_q;
    sq_d         = sq_q;
    rec_d        = rec_q;
    cnt_d        = cnt_q;
    ent0_ir_d    = ent0_ir_q;
    ent0_pc_d    = ent0_pc_q;
    ent1_ir_d    = ent1_ir_q;
    ent1_pc_d    = ent1_pc_q;
    ifid_ir_d    = ifid_ir_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    accept       = imem_req & imem_gnt;
    resp         = imem_rvalid & out_q;
    pop          = 1'b0;
    cnt_mid      = cnt_q;

    if (redirect) begin
      fpc_d        = {redirect_pc[31:2], 2'b00};
      cnt_d        = 2'd0;
      ifid_ir_d    = NOP_IR;
      ifid_valid_d = 1'b0;
      // A response still in flight belongs to the old path and must be dropped on arrival
      sq_d         = out_q & ~imem_rvalid;
      out_d        = out_q & ~imem_rvalid;
    end else begin
      if (!stall) begin
        if (cnt_q != 2'd0) begin
          ifid_ir_d    = ent0_ir_q;
          ifid_pc_d    = ent0_pc_q;
          ifid_valid_d = 1'b1;
          pop          = 1'b1;
        end else begin
          ifid_ir_d    = NOP_IR;
          ifid_valid_d = 1'b0;
        end
      end

      if (pop) begin
        ent0_ir_d = ent1_ir_q;
        ent0_pc_d = ent1_pc_q;
        cnt_mid   = cnt_q - 2'd1;
      end

      if (resp) begin
        out_d = 1'b0;
        if (sq_q) begin
          sq_d = 1'b0;
        end else if (cnt_mid == 2'd0) begin
          ent0_ir_d = imem_rdata;
          ent0_pc_d = rec_q;
          cnt_mid   = 2'd1;
        end else begin
          ent1_ir_d = imem_rdata;
          ent1_pc_d = rec_q;
          cnt_mid   = 2'd2;
        end
      end
      cnt_d = cnt_mid;

      if (accept) begin
        rec_d = fpc_q;
        fpc_d = fpc_q + 32'd4;
        out_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fpc_q        <= RESET_PC;
      out_q        <= 1'b0;
      sq_q         <= 1'b0;
      rec_q        <= 32'd0;
      cnt_q        <= 2'd0;
      ent0_ir_q    <= 32'd0;
      ent0_pc_q    <= 32'd0;
      ent1_ir_q    <= 32'd0;
      ent1_pc_q    <= 32'd0;
      ifid_ir_q    <= NOP_IR;
      ifid_pc_q    <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      fpc_q        <= fpc_d;
      out_q        <= out_d;
      sq_q         <= sq_d;
      rec_q        <= rec_d;
      cnt_q        <= cnt_d;
      ent0_ir_q    <= ent0_ir_d;
      ent0_pc_q    <= ent0_pc_d;
      ent1_ir_q    <= ent1_ir_d;
      ent1_pc_q    <= ent1_pc_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - self-checking bench for instr_fetch_stage
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc;
  logic        ifid_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_ir;
  logic [31:0] w_pc;
  logic        w_valid;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instr_fetch_stage u_dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_ir(ifid_ir), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clock(clock), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_ir(w_ir), .ifid_pc(w_pc), .ifid_valid(w_valid)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: fetch queue of {instr, pc} entries
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fpc = 32'd0;
  logic [31:0] m_rec = 32'd0;
  logic        m_out = 1'b0;
  logic        m_sq = 1'b0;
  logic [31:0] m_ir = NOP;
  logic [31:0] m_pc = 32'd0;
  logic        m_v = 1'b0;

  // Responsive memory used by the randomized and stall phases
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int unsigned mem_cnt = 0;
  int unsigned mem_lat = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_pend <= 1'b0;
    end else begin
      if (imem_rvalid && mem_pend) mem_pend <= 1'b0;
      else if (mem_pend && mem_cnt != 0) mem_cnt <= mem_cnt - 1;
      if (imem_req && imem_gnt) begin
        mem_pend <= 1'b1;
        mem_addr <= imem_addr;
        mem_cnt  <= $urandom_range(mem_lat, 0);
      end
    end
  end

  task automatic tick(input logic rst, input logic g, input logic rv, input logic [31:0] rdat,
                      input logic st, input logic rdir, input logic [31:0] rpc);
    logic er;
    @(negedge clock);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
    chk("ifid_ir", ifid_ir, m_ir);
    if (m_v) chk("ifid_pc", ifid_pc, m_pc);
    reset = rst; imem_gnt = g; imem_rvalid = rv; imem_rdata = rdat;
    stall = st; redirect = rdir; redirect_pc = rpc;
    #1;
    er = !m_out && !rdir && !rst && (mq.size() < 2);
    chk("imem_req", {31'd0, imem_req}, {31'd0, er});
    if (er) chk("imem_addr", imem_addr, m_fpc);
    if (rst) begin
      m_fpc = 32'd0; mq.delete(); m_out = 1'b0; m_sq = 1'b0;
      m_ir = NOP; m_pc = 32'd0; m_v = 1'b0;
    end else if (rdir) begin
      m_fpc = rpc & 32'hFFFF_FFFC;
      mq.delete();
      m_ir = NOP; m_v = 1'b0;
      m_sq = m_out && !rv;
      if (rv) m_out = 1'b0;
    end else begin
      if (!st) begin
        if (mq.size() > 0) begin
          m_ir = mq[0].ir; m_pc = mq[0].pc; m_v = 1'b1;
          void'(mq.pop_front());
        end else begin
          m_ir = NOP; m_v = 1'b0;
        end
      end
      if (rv && m_out) begin
        m_out = 1'b0;
        if (m_sq) m_sq = 1'b0;
        else mq.push_back(ent_t'{ir: rdat, pc: m_rec});
      end
      if (er && g) begin
        m_rec = m_fpc; m_fpc = m_fpc + 32'd4; m_out = 1'b1;
      end
    end
  endtask

  task automatic auto_tick(input logic st, input logic rdir, input logic [31:0] rpc, input logic rnd);
    logic        g;
    logic        rv;
    logic [31:0] d;
    @(posedge clock);
    #1;
    g = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
    d = $urandom;
    rv = 1'b0;
    if (mem_pend && mem_cnt == 0) begin
      rv = 1'b1; d = imem_word(mem_addr);
    end else if (!mem_pend && rnd && $urandom_range(15, 0) == 0) begin
      rv = 1'b1;
    end
    tick(1'b0, g, rv, d, st, rdir, rpc);
  endtask

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] pc_s;
    logic [31:0] ir_s;
    int n;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, NOP};
    tbl[1] = '{1, 1, imem_word(32'h0), 0, 0, 0, 0, 0, 0, 0, NOP};
    tbl[2] = '{1, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0, NOP};
    tbl[3] = '{1, 1, imem_word(32'h4), 0, 0, 0, 0, 0, 1, 32'h0, imem_word(32'h0)};
    tbl[4] = '{1, 0, 0, 0, 0, 0, 1, 32'h8, 0, 0, NOP};
    tbl[5] = '{1, 1, imem_word(32'h8), 1, 1, 32'h103, 0, 0, 1, 32'h4, imem_word(32'h4)};
    tbl[6] = '{1, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, NOP};
    tbl[7] = '{1, 1, imem_word(32'h100), 0, 0, 0, 0, 0, 0, 0, NOP};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 1, 32'h104, 0, 0, NOP};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 1, 32'h104, 1, 32'h100, imem_word(32'h100)};

    // Reset state
    tick(1, 0, 0, 0, 0, 0, 0);
    chk("rst_ifid_ir", ifid_ir, NOP);
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    tick(1, 0, 0, 0, 0, 0, 0);

    // Startup, fetch stream, stall+redirect, wrap-around instance
    for (int i = 0; i < 10; i++) begin
      tick(0, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].st, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, ifid_valid}, {31'd0, tbl[i].e_v});
      chk($sformatf("vec%0d_ir", i), ifid_ir, tbl[i].e_ir);
      if (tbl[i].e_v) chk($sformatf("vec%0d_pc", i), ifid_pc, tbl[i].e_pc);
      if (i == 0) chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      if (i == 2) chk("wrap_addr1", w_addr, 32'h0000_0000);
      if (i == 0 || i == 2) chk($sformatf("wrap_req%0d", i), {31'd0, w_req}, 32'd1);
    end

    // Redirect with a request outstanding: stale response must be dropped
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("rd_first_addr", imem_addr, 32'h0);
    tick(0, 0, 0, 0, 0, 1, 32'h0000_0103);
    chk("rd_req_blocked", {31'd0, imem_req}, 32'd0);
    tick(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("rd_req_wait_stale", {31'd0, imem_req}, 32'd0);
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("rd_new_req", {31'd0, imem_req}, 32'd1);
    chk("rd_new_addr", imem_addr, 32'h0000_0100);
    tick(0, 0, 1, imem_word(32'h100), 0, 0, 0);
    chk("rd_no_stale_valid", {31'd0, ifid_valid}, 32'd0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("rd_valid_low", {31'd0, ifid_valid}, 32'd0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("rd_valid_high", {31'd0, ifid_valid}, 32'd1);
    chk("rd_pc", ifid_pc, 32'h0000_0100);
    chk("rd_ir", ifid_ir, imem_word(32'h100));

    // Reset mid-transaction, late response afterwards
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 32'hBAD0_0001, 0, 0, 0);
    chk("late_req", {31'd0, imem_req}, 32'd1);
    chk("late_addr", imem_addr, 32'h0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("late_valid0", {31'd0, ifid_valid}, 32'd0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("late_valid1", {31'd0, ifid_valid}, 32'd0);
    chk("late_req2", {31'd0, imem_req}, 32'd1);

    // Stall for 5 cycles with a responsive memory
    tick(1, 0, 0, 0, 0, 0, 0);
    mem_lat = 0;
    n = 0;
    do begin
      auto_tick(0, 0, 0, 0);
      n++;
    end while (!m_v && n < 20);
    chk("stall_setup_valid", {31'd0, m_v}, 32'd1);
    pc_s = m_pc;
    ir_s = m_ir;
    for (int k = 0; k < 5; k++) begin
      auto_tick(1, 0, 0, 0);
      chk($sformatf("stall%0d_pc", k), ifid_pc, pc_s);
      chk($sformatf("stall%0d_ir", k), ifid_ir, ir_s);
      chk($sformatf("stall%0d_valid", k), {31'd0, ifid_valid}, 32'd1);
    end
    chk("stall_full_req", {31'd0, imem_req}, 32'd0);
    auto_tick(0, 0, 0, 0);
    chk("release_pc0", ifid_pc, pc_s);
    auto_tick(0, 0, 0, 0);
    chk("release_valid1", {31'd0, ifid_valid}, 32'd1);
    chk("release_pc1", ifid_pc, pc_s + 32'd4);
    auto_tick(0, 0, 0, 0);
    chk("release_valid2", {31'd0, ifid_valid}, 32'd1);
    chk("release_pc2", ifid_pc, pc_s + 32'd8);

    // Randomized traffic against the reference model
    tick(1, 0, 0, 0, 0, 0, 0);
    mem_lat = 3;
    for (int c = 0; c < 3000; c++) begin
      auto_tick($urandom_range(3, 0) == 0, $urandom_range(15, 0) == 0, $urandom, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter NOP_IR, default 32'h0000_0020 (add r0,r0,r0): IR emitted on bubbles.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  byte address of the request; bits [1:0] always 0.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  read data valid; responses return in order.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 stall  input  1  decode stage cannot take a new IF/ID value; hold outputs.
REQ-011 redirect  input  1  taken branch; restart fetch at redirect_pc.
REQ-012 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-013 ifid_ir  output  32  IF/ID instruction register.
REQ-014 ifid_pc  output  32  fetch address of ifid_ir.
REQ-015 ifid_valid  output  1  ifid_ir is a real fetched instruction, not a bubble.

Function
REQ-016 The block SHALL hold a fetch PC (fpc), a 2-entry prefetch FIFO of {instr, pc}, an outstanding flag (out) and a squash flag (sq).
REQ-017 imem_req SHALL be 1 exactly when: out=0, redirect=0, reset=0, and FIFO count < 2; imem_addr SHALL equal fpc.
REQ-018 On imem_req & imem_gnt, the block SHALL set fpc <= fpc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), set out=1, and record the request address.
REQ-019 At most one request SHALL be outstanding.
REQ-020 On imem_rvalid with out=1, the block SHALL clear out; if sq=0 it SHALL push {imem_rdata, recorded address}, otherwise discard and clear sq.
REQ-021 imem_rvalid with out=0 SHALL be ignored.
REQ-022 Because of the request gating, a push SHALL never target a full FIFO.
REQ-023 IF/ID update when stall=0 and redirect=0: FIFO non-empty -> load head, ifid_valid<=1, pop. FIFO empty -> ifid_ir<=NOP_IR, ifid_valid<=0, ifid_pc holds.
REQ-024 There SHALL be no bypass: an entry pushed at edge t is loaded into IF/ID no earlier than edge t+1.
REQ-025 When stall=1 and redirect=0, ifid_ir, ifid_pc, ifid_valid and the FIFO head SHALL hold; requests and pushes continue per REQ-017/020.
REQ-026 Redirect takes priority over stall, and over a same-cycle grant (imem_req is 0). On redirect=1:
- fpc <= {redirect_pc[31:2], 2'b00}
- FIFO emptied
- ifid_ir <= NOP_IR, ifid_valid <= 0
- sq <= 1 if out=1 and no imem_rvalid this cycle; otherwise sq <= 0
- a same-cycle imem_rvalid is discarded.
REQ-027 A push and a pop in the same cycle SHALL both take effect; count is unchanged.
REQ-028 Back-to-back redirects SHALL each restart fetch; only the last redirect_pc is used.

Reset
REQ-029 While reset=1, the block SHALL force:
- fpc=RESET_PC
- FIFO empty, out=0, sq=0
- ifid_ir=NOP_IR, ifid_pc=0, ifid_valid=0
- imem_req=0.
REQ-030 Reset asserted mid-transaction SHALL drop the outstanding request; a late imem_rvalid after reset release is ignored per REQ-021.
REQ-031 The first request SHALL be issued in the first cycle after reset deasserts, at address RESET_PC.

Verification
REQ-032 Reset release; memory grants immediately and returns rvalid one cycle later. Expected:
- first request at addr 0
- then requests at 4, 8
- ifid_valid first rises with ifid_pc=0 and the instruction from address 0.
REQ-033 Hold stall=1 for 5 cycles with a responsive memory. Expected:
- FIFO fills to 2
- imem_req drops to 0
- ifid_ir/ifid_pc frozen
- on stall release, IF/ID receives consecutive addresses with no gap or duplicate.
REQ-034 Assert redirect to 32'h0000_0103 while a request is outstanding. Expected:
- next request at 32'h0000_0100
- the stale response is discarded
- ifid_valid=0 until 32'h100 arrives.
REQ-035 Assert stall=1 and redirect=1 in the same cycle. Expected: redirect wins; ifid_ir=32'h0000_0020 and ifid_valid=0 next cycle.
REQ-036 Set RESET_PC=32'hFFFF_FFFC. Expected: requests at FFFF_FFFC then 0000_0000.
REQ-037 Assert reset with out=1, then pulse imem_rvalid after release. Expected: no push, ifid_valid stays 0, first request at RESET_PC.
